ex_result_stage: RTL and testbench
==================================

# ex_result_stage

Registered result stage that sits directly downstream of the EX-stage arithmetic units, including the 16-bit partitioned sub-word adder. It captures the ALU/PSA result, its overflow indication and the destination info into a 2-entry elastic buffer toward MEM, and updates the architectural Z/V/N flag register per opcode. It also keeps a saturating count of PSA overflow events for debug.

## Interface
Parameters:
- DW, 16, datapath width
- ERRCNT_W, 8, width of the PSA-overflow event counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX presents a result beat
- in_ready  out  1  stage can accept a beat
- in_result  in  DW  ALU/PSA result (PSA Sum for PADDSB)
- in_error  in  1  overflow from ALU/PSA (PSA Error for PADDSB)
- in_opcode  in  4  instruction opcode
- in_dst  in  4  destination register index
- in_wr_en  in  1  register-write enable
- flush  in  1  squash all buffered beats (branch mispredict)
- out_valid  out  1  beat available to MEM
- out_ready  in  1  MEM accepts beat
- out_result  out  DW  head result
- out_dst  out  4  head destination
- out_wr_en  out  1  head write enable
- flags  out  3  registered {Z,V,N}
- flags_fwd  out  3  next-flags view (see Configuration)
- err_cnt  out  ERRCNT_W  saturating PSA-overflow count
- err_clr  in  1  synchronous clear of err_cnt

## Operation
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- Buffer: 2 entries, head drives out_*. in_ready = !(both entries full). States EMPTY → ONE (accept) → TWO (accept without pop); TWO → ONE (pop); ONE → EMPTY (pop, no accept); accept+pop in ONE stays ONE with new beat at head next cycle; accept+pop in EMPTY impossible (out_valid=0).
- Order strictly FIFO; no beat dropped or duplicated.
- Flags update only on Accept: ADD(0000)/SUB(0001): Z=(in_result==0), V=in_error, N=in_result[DW-1]. XOR(0010), SLL(0100), SRA(0101), ROR(0110): Z only; V,N hold. PADDSB(0111), RED(0011) and all other opcodes: flags hold.
- err_cnt increments on Accept with opcode PADDSB and in_error=1; saturates at all-ones; err_clr wins over increment in the same cycle.
- flush: both entries invalidated next cycle, incoming beat ignored, flags and err_cnt not updated that cycle; flush dominates simultaneous Accept/Pop.
- Reset: out_valid=0, in_ready=1, out_result=0, out_dst=0, out_wr_en=0, flags=3'b000, err_cnt=0.

## Timing
- Latency: Accept in cycle n → out_valid with that beat in cycle n+1 (if buffer was empty).
- Throughput 1 beat/cycle while out_ready=1.
- in_ready is registered (depends only on occupancy), no combinational path from out_ready.
- flags reflect an accepted beat from cycle n+1.
- Reset asserted mid-stream: all state cleared immediately, buffered beats lost.

## Configuration
- EX_FLAG_FWD_EN defined: flags_fwd = combinational next-flags value (flags updated by current Accept), for same-cycle branch resolution.
- Undefined: flags_fwd = flags (registered); no combinational path from in_* to any output.

## Structure
- Package ex_pkg: opcode constants (OP_ADD … OP_PADDSB), flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0), flag_t typedef.
- Sub-module flag_unit: opcode decode, next-flag computation and flag register; buffer and err_cnt stay in the top.

## Test plan
- Reset, then ADD result 16'h0000 in_error=0 → flags=3'b100 next cycle, out_valid=1, out_result=0.
- PADDSB result 16'h7F70 in_error=1, prior flags 3'b010 → flags unchanged 3'b010, err_cnt 0→1.
- Hold out_ready=0, send 3 beats back-to-back → in_ready drops after 2nd accept, 3rd held; release → beats exit in order A,B,C.
- SUB result 16'h8000 in_error=1 with flush in same cycle → beat dropped, flags unchanged, out_valid=0 next cycle.
- Force 255 PADDSB overflows then one more → err_cnt stays 8'hFF; err_clr with simultaneous overflow → err_cnt=0.
- XOR result 16'h0001 after flags 3'b111 → flags=3'b011.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - opcode, flag-index and buffer-state definitions for the EX result stage
package ex_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef logic [2:0] flag_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/ex_result_stage_flag_unit.sv
// rtl/ex_result_stage_flag_unit.sv - Z/V/N flag decode and register
// EX_FLAG_FWD_EN: flags_fwd_o shows the combinational next-flags value instead of the register.
module flag_unit
  import ex_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd_i,
  input  logic [3:0]    opcode_i,
  input  logic [DW-1:0] result_i,
  input  logic          error_i,
  output flag_t         flags_o,
  output flag_t         flags_fwd_o
);

  flag_t flags_q, flags_d;
  logic  zero;

  assign zero = (result_i == '0);

  always_comb begin
    flags_d = flags_q;
    if (upd_i) begin
      case (opcode_i)
        OP_ADD, OP_SUB: begin
          flags_d[FLAG_Z] = zero;
          flags_d[FLAG_V] = error_i;
          flags_d[FLAG_N] = result_i[DW-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLAG_Z] = zero;
        default: flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags_o = flags_q;

`ifdef EX_FLAG_FWD_EN
  assign flags_fwd_o = flags_d;
`else
  assign flags_fwd_o = flags_q;
`endif

endmodule

// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - 2-entry result buffer toward MEM, flag update and PSA overflow counter
// EX_FLAG_FWD_EN (in flag_unit) selects the combinational flags_fwd view.
module ex_result_stage
  import ex_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_result,
  input  logic                in_error,
  input  logic [3:0]          in_opcode,
  input  logic [3:0]          in_dst,
  input  logic                in_wr_en,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_result,
  output logic [3:0]          out_dst,
  output logic                out_wr_en,
  output logic [2:0]          flags,
  output logic [2:0]          flags_fwd,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                err_clr
);

  buf_state_e          state_q, state_d;
  logic [DW-1:0]       head_res_q, head_res_d, tail_res_q, tail_res_d;
  logic [3:0]          head_dst_q, head_dst_d, tail_dst_q, tail_dst_d;
  logic                head_we_q, head_we_d, tail_we_q, tail_we_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                accept, pop;

  // in_ready comes straight from the occupancy register, never from out_ready
  assign in_ready  = (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_dst_d = head_dst_q;
    head_we_d  = head_we_q;
    tail_res_d = tail_res_q;
    tail_dst_d = tail_dst_q;
    tail_we_d  = tail_we_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) begin
          head_res_d = in_result; head_dst_d = in_dst; head_we_d = in_wr_en;
          state_d    = BUF_ONE;
        end
        BUF_ONE: begin
          if (accept && pop) begin
            head_res_d = in_result; head_dst_d = in_dst; head_we_d = in_wr_en;
          end else if (accept) begin
            tail_res_d = in_result; tail_dst_d = in_dst; tail_we_d = in_wr_en;
            state_d    = BUF_TWO;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: if (pop) begin
          head_res_d = tail_res_q; head_dst_d = tail_dst_q; head_we_d = tail_we_q;
          state_d    = BUF_ONE;
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (accept && in_opcode == OP_PADDSB && in_error && err_cnt_q != {ERRCNT_W{1'b1}})
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      head_res_q <= '0;
      head_dst_q <= '0;
      head_we_q  <= 1'b0;
      tail_res_q <= '0;
      tail_dst_q <= '0;
      tail_we_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_res_q <= head_res_d;
      head_dst_q <= head_dst_d;
      head_we_q  <= head_we_d;
      tail_res_q <= tail_res_d;
      tail_dst_q <= tail_dst_d;
      tail_we_q  <= tail_we_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_result = head_res_q;
  assign out_dst    = head_dst_q;
  assign out_wr_en  = head_we_q;
  assign err_cnt    = err_cnt_q;

  flag_unit #(.DW(DW)) u_flag_unit (
    .clk        (clk),
    .rst        (rst),
    .upd_i      (accept),
    .opcode_i   (in_opcode),
    .result_i   (in_result),
    .error_i    (in_error),
    .flags_o    (flags),
    .flags_fwd_o(flags_fwd)
  );

endmodule

// File: tb/tb_ex_result_stage.sv
// tb/tb_ex_result_stage.sv - scoreboard bench for ex_result_stage with a queue/arithmetic reference model
module tb_ex_result_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 0, in_ready, in_error = 0, in_wr_en = 0, flush = 0;
  logic [15:0] in_result = 0, out_result;
  logic [3:0]  in_opcode = 0, in_dst = 0, out_dst;
  logic        out_valid, out_ready = 0, out_wr_en, err_clr = 0;
  logic [2:0]  flags, flags_fwd;
  logic [7:0]  err_cnt;

  ex_result_stage #(.DW(16), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_error(in_error), .in_opcode(in_opcode),
    .in_dst(in_dst), .in_wr_en(in_wr_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_wr_en(out_wr_en), .flags(flags),
    .flags_fwd(flags_fwd), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] res; logic [3:0] dst; logic we; } beat_t;
  beat_t      sb[$];
  beat_t      b;
  int         checks = 0, passed = 0, occ;
  logic [2:0] mflags = 0, nflags = 0;
  logic [7:0] merr = 0, nerr = 0;
  bit         pend = 0, prev_flush = 0, run = 0, a;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Flag rules: arithmetic sets all three, logic/shift ops only Z, everything else holds.
  function automatic logic [2:0] ref_flags(logic [2:0] f, logic [3:0] op, logic [15:0] r, logic e);
    logic z;
    z = (r == 16'd0);
    if (op == 4'd0 || op == 4'd1) return {z, e, r[15]};
    if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return {z, f[1:0]};
    return f;
  endfunction

  task automatic cyc(bit v, logic [15:0] r, bit e, logic [3:0] op, logic [3:0] d, bit we,
                     bit fl, bit ordy, bit clr, output bit acc);
    @(posedge clk); #1;
    if (prev_flush) sb.delete();
    mflags = nflags;
    merr   = nerr;
    in_valid = v; in_result = r; in_error = e; in_opcode = op; in_dst = d; in_wr_en = we;
    flush = fl; out_ready = ordy; err_clr = clr;
    acc  = v && (sb.size() < 2) && !fl;
    pend = acc;
    if (acc) sb.push_back('{r, d, we});
    nflags = acc ? ref_flags(mflags, op, r, e) : mflags;
    if (clr) nerr = 8'd0;
    else if (acc && op == 4'd7 && e && merr != 8'hFF) nerr = merr + 8'd1;
    else nerr = merr;
    prev_flush = fl;
  endtask

  task automatic idle(bit ordy);
    bit x;
    cyc(0, 16'h0, 0, 4'h0, 4'h0, 0, 0, ordy, 0, x);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    idle(1);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic send_until(logic [15:0] r, bit e, logic [3:0] op, logic [3:0] d, bit ordy);
    bit x;
    x = 0;
    for (int i = 0; i < 8 && !x; i++) cyc(1, r, e, op, d, 1, 0, ordy, 0, x);
    if (!x) chk("send_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (run) begin
      occ = sb.size() - int'(pend);
      chk("out_valid", out_valid, occ != 0);
      chk("in_ready", in_ready, occ < 2);
      chk("flags", flags, mflags);
      chk("err_cnt", err_cnt, merr);
`ifdef EX_FLAG_FWD_EN
      chk("flags_fwd", flags_fwd, nflags);
`else
      chk("flags_fwd", flags_fwd, mflags);
`endif
      if (out_valid && out_ready && !flush) begin
        if (occ == 0) chk("pop_unexpected", 1, 0);
        else begin
          b = sb.pop_front();
          chk("out_result", out_result, b.res);
          chk("out_dst", out_dst, b.dst);
          chk("out_wr_en", out_wr_en, b.we);
        end
      end
    end
  end

  task automatic reset_checks(string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_dst"}, out_dst, 0);
    chk({tag, "_out_wr_en"}, out_wr_en, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #1;
    rst = 0;
    run = 1;

    // ADD zero -> Z set, beat out next cycle
    cyc(1, 16'h0000, 0, 4'h0, 4'h1, 1, 0, 0, 0, a);
    cyc(1, 16'h0001, 1, 4'h0, 4'h2, 1, 0, 1, 0, a);
    drain();
    // PADDSB overflow with flags 010 -> flags hold, counter 1
    cyc(1, 16'h7F70, 1, 4'h7, 4'h3, 0, 0, 1, 0, a);
    drain();
    // backpressure: A,B accepted, C held until space
    cyc(1, 16'hAAAA, 0, 4'h2, 4'hA, 1, 0, 0, 0, a);
    cyc(1, 16'hBBBB, 0, 4'h2, 4'hB, 1, 0, 0, 0, a);
    cyc(1, 16'hCCCC, 0, 4'h2, 4'hC, 1, 0, 0, 0, a);
    if (a) chk("third_beat_held", a, 0);
    send_until(16'hCCCC, 0, 4'h2, 4'hC, 1);
    drain();
    // SUB with simultaneous flush -> dropped
    cyc(1, 16'h1234, 0, 4'h5, 4'h4, 1, 0, 0, 0, a);
    cyc(1, 16'h8000, 1, 4'h1, 4'h5, 1, 1, 1, 0, a);
    idle(1);
    idle(1);
    // counter saturation, then clear beats simultaneous overflow
    for (int i = 0; i < 260; i++) cyc(1, 16'h7F7F, 1, 4'h7, 4'h6, 0, 0, 1, 0, a);
    cyc(1, 16'h7F7F, 1, 4'h7, 4'h6, 0, 0, 1, 1, a);
    drain();
    // flags 111 then XOR nonzero -> 011
    cyc(1, 16'h8000, 1, 4'h0, 4'h7, 1, 0, 1, 0, a);
    cyc(1, 16'h0000, 0, 4'h2, 4'h7, 1, 0, 1, 0, a);
    cyc(1, 16'h0001, 0, 4'h2, 4'h7, 1, 0, 1, 0, a);
    drain();

    for (int i = 0; i < 2000; i++) begin
      bit fl;
      logic [3:0] op;
      fl = ($urandom % 16) == 0;
      op = ($urandom % 4 == 0) ? 4'd7 : 4'($urandom % 16);
      cyc(($urandom % 4) != 0, ($urandom % 6 == 0) ? 16'h0 : 16'($urandom), $urandom % 2, op,
          4'($urandom), $urandom % 2, fl, ($urandom % 3) != 0, !fl && ($urandom % 40 == 0), a);
    end
    drain();

    // asynchronous reset mid-stream
    cyc(1, 16'h8001, 1, 4'h0, 4'h8, 1, 0, 0, 0, a);
    cyc(1, 16'h0002, 1, 4'h7, 4'h9, 1, 0, 0, 0, a);
    @(negedge clk);
    run = 0;
    #2 rst = 1;
    #1 reset_checks("midreset");
    sb.delete();
    mflags = 0; nflags = 0; merr = 0; nerr = 0; pend = 0; prev_flush = 0;
    in_valid = 0; flush = 0; err_clr = 0; out_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    run = 1;
    cyc(1, 16'h0055, 0, 4'h1, 4'hD, 1, 0, 1, 0, a);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
